timer_cmd_arbiter: RTL
======================

TIMER_CMD_ARBITER -- requirements
Module: timer_cmd_arbiter

Interface
REQ-001 SHALL have parameter REPEAT_DELAY, default 25000000; cycles a seg/min level must be held before the first auto-repeat.
REQ-002 SHALL have parameter REPEAT_PERIOD, default 5000000; cycles between auto-repeats after the first.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port btn_cmd  input  5  source A (push buttons) levels, already synchronized; bit map [0]=start, [1]=stop, [2]=delete, [3]=segDemand, [4]=minDemand.
REQ-006 SHALL have port key_cmd  input  5  source B (keyboard decoder) levels, already synchronized; same bit map as btn_cmd.
REQ-007 SHALL have outputs start, stop, delete, segDemand, minDemand  output  1 each  registered single-cycle command pulses to the timer state machine.
REQ-008 SHALL have port grant_src  output  1  source of the current pulse (0=A, 1=B); valid only while a pulse is high.
REQ-009 SHALL have port pending  output  10  {B pending[4:0], A pending[4:0]}, for debug and display.

Function
REQ-010 SHALL register each source's level vector every cycle; a rising edge is the current sample high with the previous sample low.
REQ-011 SHALL set the matching pending bit of that source on the clock edge where a rising edge is detected; a bit that is already set stays set, with no counting.
REQ-012 SHALL, each cycle, select a source with any pending bit set: if only one source qualifies, that source; if both qualify, the one named by the round-robin pointer.
REQ-013 SHALL, within the selected source, issue the highest-priority pending bit in the order delete > stop > start > minDemand > segDemand.
REQ-014 SHALL, on the next edge, drive exactly that output pulse high for one cycle, drive grant_src, and clear the issued bit.
REQ-015 SHALL toggle the round-robin pointer to the other source after every grant made while both sources were pending; otherwise the pointer is unchanged.
REQ-016 SHALL, when the same command bit is pending in both sources at selection, issue a single pulse and clear the bit in both sources; grant_src names the selected source.
REQ-017 SHALL, when a delete is issued from a source, clear that source's pending start, segDemand and minDemand bits on the same edge.
REQ-018 SHALL have a fixed latency: input high at posedge k, low at k-1, no contention -> pulse high during the cycle after posedge k+1.
REQ-019 SHALL assert at most one of the five command outputs in any cycle; with no pending bits, all five outputs are 0.
REQ-020 SHALL continue to set pending bits while a pulse is being issued; no edge is lost.

Reset
REQ-021 SHALL, while reset is high, asynchronously clear all command outputs, grant_src, the pending bits, the edge-detect registers, the repeat counters, and the round-robin pointer (pointer = source A).
REQ-022 SHALL discard any operation in progress when reset is asserted mid-operation; after release, a level still held high SHALL NOT count as a rising edge until it goes low and high again.

Configuration
REQ-023 SHALL, with macro TIMER_AUTO_REPEAT_EN defined, keep one 26-bit repeat counter per source for segDemand/minDemand.
REQ-024 SHALL, with the macro defined, re-set the pending bit when the level is held REPEAT_DELAY cycles after its rising edge, then every REPEAT_PERIOD cycles.
REQ-025 SHALL, with the macro defined, restart the repeat counter on any change of that source's seg/min levels; if both seg and min are held, only minDemand repeats.
REQ-026 SHALL, without TIMER_AUTO_REPEAT_EN, generate pending bits only from rising edges, with no repeat counters synthesized.

Verification
REQ-027 SHALL cover: btn_cmd=00001 rising at posedge 10 -> start=1 in the cycle after posedge 11 only, grant_src=0, pending=0 afterwards.
REQ-028 SHALL cover: btn_cmd[1] and key_cmd[0] rising at the same edge, pointer=A -> stop pulse (src 0), then start pulse (src 1) the next cycle.
REQ-029 SHALL cover: both sources raise segDemand at the same edge -> exactly one segDemand pulse, and both pending bits cleared.
REQ-030 SHALL cover: A pending start+segDemand, then delete rises -> delete pulse issued and A pending=00000; no start or seg pulse follows.
REQ-031 SHALL cover: with TIMER_AUTO_REPEAT_EN, REPEAT_DELAY=8, REPEAT_PERIOD=4, btn_cmd[3] held 20 cycles -> seg pulses at the edge, +8 and +12 cycles after, and +16 if still held; without the macro -> one pulse.
REQ-032 SHALL cover: reset asserted between the pending set and the pulse -> no pulse, all outputs 0; held input after release -> no pulse until it is re-pressed.

Source files
------------

// File: rtl/timer_cmd_arbiter.sv
// timer_cmd_arbiter
//   Merges command requests from two sources (push buttons and a keyboard
//   decoder) into single-cycle command pulses for the timer state machine.
//   Each source's rising edges latch into a per-source pending vector. One
//   command is issued per cycle. Sources alternate round-robin when both have
//   work. Within a source the order is delete > stop > start > min > seg.
//
//   Optional feature macro: TIMER_AUTO_REPEAT_EN
//     When defined, a held segDemand/minDemand level re-arms its pending bit
//     after REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles.
//
// Ports
//   clk        system clock, all state changes on posedge
//   reset      asynchronous, active-high reset
//   btn_cmd    source A levels {minDemand, segDemand, delete, stop, start}
//   key_cmd    source B levels, same bit map as btn_cmd
//   start, stop, delete, segDemand, minDemand
//              registered one-cycle command pulses, at most one high at a time
//   grant_src  source of the current pulse (0 = A, 1 = B)
//   pending    {B pending[4:0], A pending[4:0]}
module timer_cmd_arbiter #(
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] btn_cmd,
  input  logic [4:0] key_cmd,
  output logic       start,
  output logic       stop,
  output logic       delete,
  output logic       segDemand,
  output logic       minDemand,
  output logic       grant_src,
  output logic [9:0] pending
);

  localparam int unsigned BitStart  = 0;
  localparam int unsigned BitStop   = 1;
  localparam int unsigned BitDelete = 2;
  localparam int unsigned BitSeg    = 3;
  localparam int unsigned BitMin    = 4;

  // A delete cancels the issuing source's queued start/seg/min requests
  localparam logic [4:0] DeleteClears = 5'b11001;

  logic [1:0][4:0] level;
  logic [1:0][4:0] prev_q;
  logic            primed_q;
  logic [1:0][4:0] rise;
  logic [1:0][4:0] repeatSet;
  logic [1:0][4:0] pend_q, pend_d;
  logic            rrPtr_q, rrPtr_d;
  logic [4:0]      pulse_q, pulse_d;
  logic            grantSrc_q, grantSrc_d;
  logic            anyA, anyB, selB;
  logic [4:0]      selPend, issue;

  assign level[0] = btn_cmd;
  assign level[1] = key_cmd;

  // Edges are masked for the first cycle after reset so that a level still
  // held through reset must be released and pressed again to count.
  assign rise[0] = primed_q ? (level[0] & ~prev_q[0]) : 5'b0;
  assign rise[1] = primed_q ? (level[1] & ~prev_q[1]) : 5'b0;

`ifdef TIMER_AUTO_REPEAT_EN
  localparam logic [25:0] DelayCnt  = 26'(REPEAT_DELAY);
  localparam logic [25:0] PeriodCnt = 26'(REPEAT_PERIOD);

  for (genvar s = 0; s < 2; s++) begin : gRepeat
    logic [25:0] cnt_q, cnt_d, cntInc;
    logic        phase_q, phase_d, armed_q, armed_d;
    logic        held, changed;
    logic [4:0]  setBits;

    assign held    = level[s][BitMin] | level[s][BitSeg];
    assign changed = level[s][BitMin:BitSeg] != prev_q[s][BitMin:BitSeg];
    assign cntInc  = cnt_q + 26'd1;

    // Counts cycles since the last change of the seg/min levels. The first
    // match uses the delay, later ones the period. Only a hold that began
    // with a genuine rising edge (armed) may re-set a pending bit, and min
    // wins when both levels are held.
    always_comb begin
      cnt_d   = cntInc;
      phase_d = phase_q;
      setBits = 5'b0;
      armed_d = held & (armed_q | rise[s][BitMin] | rise[s][BitSeg]);
      if (!held || changed) begin
        cnt_d   = 26'd0;
        phase_d = 1'b0;
      end else if (cntInc == (phase_q ? PeriodCnt : DelayCnt)) begin
        cnt_d   = 26'd0;
        phase_d = 1'b1;
        setBits[BitMin] = armed_q & level[s][BitMin];
        setBits[BitSeg] = armed_q & level[s][BitSeg] & ~level[s][BitMin];
      end
    end

    // Repeat counter state for this source
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q   <= 26'd0;
        phase_q <= 1'b0;
        armed_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        phase_q <= phase_d;
        armed_q <= armed_d;
      end
    end

    assign repeatSet[s] = setBits;
  end
`else
  assign repeatSet = '0;
`endif

  // Arbitration: pick a source (round-robin only under contention), take its
  // highest-priority pending bit, clear it in both sources so a duplicate
  // request collapses into one pulse, then merge in this cycle's new edges
  // last so nothing arriving during an issue is lost.
  always_comb begin
    anyA    = |pend_q[0];
    anyB    = |pend_q[1];
    selB    = anyB & (~anyA | rrPtr_q);
    selPend = selB ? pend_q[1] : pend_q[0];
    issue   = 5'b0;
    if (selPend[BitDelete])      issue[BitDelete] = 1'b1;
    else if (selPend[BitStop])   issue[BitStop]   = 1'b1;
    else if (selPend[BitStart])  issue[BitStart]  = 1'b1;
    else if (selPend[BitMin])    issue[BitMin]    = 1'b1;
    else if (selPend[BitSeg])    issue[BitSeg]    = 1'b1;

    pend_d[0] = pend_q[0] & ~issue;
    pend_d[1] = pend_q[1] & ~issue;
    if (issue[BitDelete]) begin
      pend_d[selB] = pend_d[selB] & ~DeleteClears;
    end
    pend_d[0] = pend_d[0] | rise[0] | repeatSet[0];
    pend_d[1] = pend_d[1] | rise[1] | repeatSet[1];

    rrPtr_d    = (anyA & anyB) ? ~rrPtr_q : rrPtr_q;
    pulse_d    = issue;
    grantSrc_d = selB;
  end

  // Edge-detect history, pending vectors, pointer and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q     <= '0;
      primed_q   <= 1'b0;
      pend_q     <= '0;
      rrPtr_q    <= 1'b0;
      pulse_q    <= 5'b0;
      grantSrc_q <= 1'b0;
    end else begin
      prev_q     <= level;
      primed_q   <= 1'b1;
      pend_q     <= pend_d;
      rrPtr_q    <= rrPtr_d;
      pulse_q    <= pulse_d;
      grantSrc_q <= grantSrc_d;
    end
  end

  assign start     = pulse_q[BitStart];
  assign stop      = pulse_q[BitStop];
  assign delete    = pulse_q[BitDelete];
  assign segDemand = pulse_q[BitSeg];
  assign minDemand = pulse_q[BitMin];
  assign grant_src = grantSrc_q;
  assign pending   = {pend_q[1], pend_q[0]};

endmodule
